// File: rtl/reg_operand_reader_pkg.sv
// Shared widths, output-stage state encoding and operand helpers for the
// ID->EX operand reader.
package reg_operand_reader_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 32;
   localparam int NREG   = 2 ** REG_AW;

   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   // A writeback in the same cycle satisfies a pending read of that register.
   function automatic logic wb_hit(input logic              wb_valid,
                                   input logic [REG_AW-1:0] wb_rd,
                                   input logic [REG_AW-1:0] idx);
      return wb_valid && (wb_rd == idx) && (idx != REG_ZERO);
   endfunction

   function automatic logic [XLEN-1:0] sel_operand(input logic [REG_AW-1:0] idx,
                                                   input logic              hit,
                                                   input logic [XLEN-1:0]   wb_data,
                                                   input logic [XLEN-1:0]   rf_value);
      if (idx == REG_ZERO) return '0;
      else if (hit)        return wb_data;
      else                 return rf_value;
   endfunction

endpackage

// File: rtl/reg_operand_reader_if.sv
// Decode-side, register-file, writeback and EX-side signals of the operand
// reader; slave is the reader, master is its environment.
interface reg_operand_reader_if;
   import reg_operand_reader_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   in_pc;
   logic [REG_AW-1:0] in_rs1;
   logic [REG_AW-1:0] in_rs2;
   logic              in_use_rs1;
   logic              in_use_rs2;
   logic [REG_AW-1:0] in_rd;
   logic              in_wr_rd;

   logic [REG_AW-1:0] rf_rs1;
   logic [REG_AW-1:0] rf_rs2;
   logic [XLEN-1:0]   rf_rs1_value;
   logic [XLEN-1:0]   rf_rs2_value;

   logic              wb_valid;
   logic [REG_AW-1:0] wb_rd;
   logic [XLEN-1:0]   wb_data;

   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_pc;
   logic [REG_AW-1:0] out_rd;
   logic              out_wr_rd;
   logic [XLEN-1:0]   out_rs1_value;
   logic [XLEN-1:0]   out_rs2_value;

   modport slave (
      input  in_valid, in_pc, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_wr_rd,
      output in_ready,
      output rf_rs1, rf_rs2,
      input  rf_rs1_value, rf_rs2_value,
      input  wb_valid, wb_rd, wb_data,
      output out_valid, out_pc, out_rd, out_wr_rd, out_rs1_value, out_rs2_value,
      input  out_ready
   );

   modport master (
      output in_valid, in_pc, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_wr_rd,
      input  in_ready,
      input  rf_rs1, rf_rs2,
      output rf_rs1_value, rf_rs2_value,
      output wb_valid, wb_rd, wb_data,
      input  out_valid, out_pc, out_rd, out_wr_rd, out_rs1_value, out_rs2_value,
      output out_ready
   );

endinterface

// File: rtl/reg_operand_reader_scoreboard.sv
// One busy bit per register marking an outstanding write; looked up for
// rs1, rs2 (RAW) and rd (WAW).
module reg_operand_reader_scoreboard
   import reg_operand_reader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_idx,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_idx,
   input  logic [REG_AW-1:0] rd_idx_a,
   input  logic [REG_AW-1:0] rd_idx_b,
   input  logic [REG_AW-1:0] rd_idx_c,
   output logic              busy_a,
   output logic              busy_b,
   output logic              busy_c
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   // Set is applied after clear so a retiring and a newly issued write to the
   // same register leave it busy.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[clr_idx] = 1'b0;
      if (set_en) busy_d[set_idx] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) busy_q <= '0;
      else               busy_q <= busy_d;
   end

   assign busy_a = busy_q[rd_idx_a];
   assign busy_b = busy_q[rd_idx_b];
   assign busy_c = busy_q[rd_idx_c];

endmodule

// File: rtl/reg_operand_reader.sv
// ID->EX operand issue: hazard check against the busy scoreboard, writeback
// bypass, one-entry output register and stall counter.
//
// state     | meaning
// OUT_EMPTY | no operands held for EX
// OUT_FULL  | output register holds an issued instruction (out_valid=1)
module reg_operand_reader
   import reg_operand_reader_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   reg_operand_reader_if.slave    bus,
   output logic [CNT_W-1:0]       stall_cnt
);

   out_state_t state_q, state_d;

   logic hit1, hit2, hitw;
   logic busy1, busy2, busyw;
   logic hz1, hz2, hzw;
   logic in_ready_w;
   logic accept;

   assign bus.rf_rs1 = bus.in_rs1;
   assign bus.rf_rs2 = bus.in_rs2;

   assign hit1 = wb_hit(bus.wb_valid, bus.wb_rd, bus.in_rs1);
   assign hit2 = wb_hit(bus.wb_valid, bus.wb_rd, bus.in_rs2);
   assign hitw = wb_hit(bus.wb_valid, bus.wb_rd, bus.in_rd);

   assign hz1 = bus.in_use_rs1 && (bus.in_rs1 != REG_ZERO) && busy1 && !hit1;
   assign hz2 = bus.in_use_rs2 && (bus.in_rs2 != REG_ZERO) && busy2 && !hit2;
   assign hzw = bus.in_wr_rd   && (bus.in_rd  != REG_ZERO) && busyw && !hitw;

   assign in_ready_w = rst && !flush && (state_q == OUT_EMPTY || bus.out_ready)
                       && !hz1 && !hz2 && !hzw;
   assign accept     = bus.in_valid && in_ready_w;
   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = (state_q == OUT_FULL);

   reg_operand_reader_scoreboard u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .clr_en   (bus.wb_valid),
      .clr_idx  (bus.wb_rd),
      .set_en   (accept && bus.in_wr_rd && (bus.in_rd != REG_ZERO)),
      .set_idx  (bus.in_rd),
      .rd_idx_a (bus.in_rs1),
      .rd_idx_b (bus.in_rs2),
      .rd_idx_c (bus.in_rd),
      .busy_a   (busy1),
      .busy_b   (busy2),
      .busy_c   (busyw)
   );

   always_ff @(posedge clk) begin
      if (!rst) state_q <= OUT_EMPTY;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush)                                    state_d = OUT_EMPTY;
      else if (accept)                              state_d = OUT_FULL;
      else if (state_q == OUT_FULL && bus.out_ready) state_d = OUT_EMPTY;
   end

   // Output payload only moves on accept, so it holds under backpressure.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.out_pc        <= '0;
         bus.out_rd        <= '0;
         bus.out_wr_rd     <= 1'b0;
         bus.out_rs1_value <= '0;
         bus.out_rs2_value <= '0;
      end else if (accept) begin
         bus.out_pc        <= bus.in_pc;
         bus.out_rd        <= bus.in_rd;
         bus.out_wr_rd     <= bus.in_wr_rd;
         bus.out_rs1_value <= sel_operand(bus.in_rs1, hit1, bus.wb_data, bus.rf_rs1_value);
         bus.out_rs2_value <= sel_operand(bus.in_rs2, hit2, bus.wb_data, bus.rf_rs2_value);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         stall_cnt <= '0;
      else if (bus.in_valid && !in_ready_w && !flush && stall_cnt != '1)
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_reg_operand_reader.sv
// Bench for reg_operand_reader: per-cycle reference of the hazard rules with
// an expected-issue queue checked against the output register.
module tb_reg_operand_reader;
   import reg_operand_reader_pkg::*;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        wr;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] stall_cnt;

   reg_operand_reader_if bus ();

   reg_operand_reader dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .bus       (bus),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   logic [31:0] rf_mem [32];
   assign bus.rf_rs1_value = (bus.rf_rs1 == 5'd0) ? 32'h1234 : rf_mem[bus.rf_rs1];
   assign bus.rf_rs2_value = (bus.rf_rs2 == 5'd0) ? 32'h1234 : rf_mem[bus.rf_rs2];

   logic [31:0] m_busy;
   logic        m_full;
   logic [31:0] m_stall;
   exp_t        q[$];

   int n_cmp = 0;
   int n_err = 0;

   logic        obs_rdy, obs_ov;
   logic [31:0] obs_stall, obs_pc, obs_rs1v, obs_rs2v;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic wbc(input logic [4:0] r);
      return bus.wb_valid && bus.wb_rd == r && r != 5'd0;
   endfunction

   function automatic logic [31:0] opnd(input logic [4:0] r);
      if (r == 5'd0)  return 32'h0;
      else if (wbc(r)) return bus.wb_data;
      else            return rf_mem[r];
   endfunction

   task automatic cycle();
      logic h1, h2, hw, exp_rdy, acc;
      exp_t e, e_new;
      @(negedge clk);
      h1 = bus.in_use_rs1 && bus.in_rs1 != 5'd0 && m_busy[bus.in_rs1] && !wbc(bus.in_rs1);
      h2 = bus.in_use_rs2 && bus.in_rs2 != 5'd0 && m_busy[bus.in_rs2] && !wbc(bus.in_rs2);
      hw = bus.in_wr_rd   && bus.in_rd  != 5'd0 && m_busy[bus.in_rd]  && !wbc(bus.in_rd);
      exp_rdy = rst && !flush && (!m_full || bus.out_ready) && !h1 && !h2 && !hw;
      acc = bus.in_valid && exp_rdy;
      obs_rdy = bus.in_ready; obs_ov = bus.out_valid; obs_stall = stall_cnt;
      obs_pc = bus.out_pc; obs_rs1v = bus.out_rs1_value; obs_rs2v = bus.out_rs2_value;
      check("in_ready", bus.in_ready, exp_rdy);
      check("out_valid", bus.out_valid, m_full);
      check("stall_cnt", stall_cnt, m_stall);
      check("rf_rs1", bus.rf_rs1, bus.in_rs1);
      check("rf_rs2", bus.rf_rs2, bus.in_rs2);
      if (m_full) begin
         check("q_size", q.size(), 1);
         if (q.size() > 0) begin
            e = q[0];
            check("out_pc", bus.out_pc, e.pc);
            check("out_rd", bus.out_rd, e.rd);
            check("out_wr_rd", bus.out_wr_rd, e.wr);
            check("out_rs1_value", bus.out_rs1_value, e.a);
            check("out_rs2_value", bus.out_rs2_value, e.b);
         end
      end
      e_new = '{bus.in_pc, bus.in_rd, bus.in_wr_rd, opnd(bus.in_rs1), opnd(bus.in_rs2)};
      @(posedge clk);
      #1;
      if (!rst) begin
         m_busy = '0; m_full = 1'b0; m_stall = '0; q.delete();
      end else if (flush) begin
         m_busy = '0;
         if (m_full && q.size() > 0) void'(q.pop_front());
         m_full = 1'b0;
      end else begin
         if (m_full && bus.out_ready && q.size() > 0) void'(q.pop_front());
         if (bus.in_valid && !exp_rdy && m_stall != '1) m_stall = m_stall + 1;
         if (bus.wb_valid) m_busy[bus.wb_rd] = 1'b0;
         if (acc && bus.in_wr_rd && bus.in_rd != 5'd0) m_busy[bus.in_rd] = 1'b1;
         if (acc) begin
            q.push_back(e_new);
            m_full = 1'b1;
         end else if (bus.out_ready) m_full = 1'b0;
      end
      if (rst && bus.wb_valid && bus.wb_rd != 5'd0) rf_mem[bus.wb_rd] = bus.wb_data;
   endtask

   task automatic set_in(input logic v, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wr);
      bus.in_valid = v; bus.in_pc = pc;
      bus.in_rs1 = rs1; bus.in_use_rs1 = u1;
      bus.in_rs2 = rs2; bus.in_use_rs2 = u2;
      bus.in_rd = rd; bus.in_wr_rd = wr;
   endtask

   task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
      bus.wb_valid = v; bus.wb_rd = rd; bus.wb_data = d;
   endtask

   task automatic idle(input int n);
      set_in(0, 32'h0, 0, 0, 0, 0, 0, 0);
      set_wb(0, 0, 32'h0);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + i;
      m_busy = '0; m_full = 1'b0; m_stall = '0;
      rst = 1'b0; flush = 1'b0; bus.out_ready = 1'b1;
      set_wb(0, 0, 32'h0);

      // Reset with an instruction offered
      set_in(1, 32'h80, 5'd1, 1, 5'd2, 1, 5'd3, 1);
      for (int i = 0; i < 3; i++) cycle();
      check("rst_in_ready", obs_rdy, 1'b0);
      check("rst_out_valid", obs_ov, 1'b0);
      check("rst_stall_cnt", obs_stall, 32'h0);
      check("rst_out_pc", bus.out_pc, 32'h0);
      check("rst_out_rs1", bus.out_rs1_value, 32'h0);
      rst = 1'b1;

      // RAW stall resolved by same-cycle writeback bypass
      set_in(1, 32'h100, 5'd1, 1, 5'd2, 1, 5'd5, 1);
      cycle();
      set_in(1, 32'h104, 5'd5, 1, 5'd0, 0, 5'd6, 1);
      for (int i = 0; i < 3; i++) cycle();
      check("raw_stalled", obs_rdy, 1'b0);
      set_wb(1, 5'd5, 32'hDEADBEEF);
      cycle();
      check("raw_stall_cnt", obs_stall, 32'd3);
      check("raw_accept", obs_rdy, 1'b1);
      idle(1);
      check("raw_bypass_op", obs_rs1v, 32'hDEADBEEF);
      set_wb(1, 5'd6, 32'h66);
      cycle();
      idle(1);

      // x0 sources/destination
      set_in(1, 32'h200, 5'd0, 1, 5'd0, 1, 5'd0, 1);
      cycle();
      set_in(1, 32'h204, 5'd0, 1, 5'd0, 1, 5'd0, 1);
      cycle();
      check("x0_no_stall", obs_rdy, 1'b1);
      check("x0_rs1_zero", obs_rs1v, 32'h0);
      check("x0_rs2_zero", obs_rs2v, 32'h0);
      idle(2);

      // Backpressure then back-to-back issue
      bus.out_ready = 1'b0;
      set_in(1, 32'h300, 5'd1, 1, 5'd2, 1, 5'd10, 1);
      cycle();
      set_in(1, 32'h304, 5'd3, 1, 5'd4, 1, 5'd11, 1);
      for (int i = 0; i < 4; i++) cycle();
      check("bp_hold_pc", obs_pc, 32'h300);
      check("bp_in_ready", obs_rdy, 1'b0);
      bus.out_ready = 1'b1;
      cycle();
      check("bp_b2b_accept", obs_rdy, 1'b1);
      idle(1);
      check("bp_b2b_valid", obs_ov, 1'b1);
      check("bp_b2b_pc", obs_pc, 32'h304);
      set_wb(1, 5'd10, 32'hA0); cycle();
      set_wb(1, 5'd11, 32'hB0); cycle();
      idle(1);

      // Same-index clear and set: set wins
      set_in(1, 32'h400, 5'd1, 1, 5'd2, 1, 5'd7, 1);
      cycle();
      set_in(1, 32'h404, 5'd1, 1, 5'd0, 0, 5'd7, 1);
      set_wb(1, 5'd7, 32'h77);
      cycle();
      check("same_idx_accept", obs_rdy, 1'b1);
      set_wb(0, 0, 32'h0);
      set_in(1, 32'h408, 5'd7, 1, 5'd0, 0, 5'd0, 0);
      cycle();
      check("same_idx_busy", obs_rdy, 1'b0);
      set_wb(1, 5'd7, 32'h7777);
      cycle();
      idle(2);

      // Flush with a held instruction and pending writes
      set_in(1, 32'h500, 5'd0, 0, 5'd0, 0, 5'd3, 1);
      cycle();
      set_in(1, 32'h504, 5'd0, 0, 5'd0, 0, 5'd9, 1);
      cycle();
      bus.out_ready = 1'b0;
      flush = 1'b1;
      set_in(1, 32'h508, 5'd1, 1, 5'd2, 1, 5'd12, 1);
      cycle();
      check("flush_no_accept", obs_rdy, 1'b0);
      flush = 1'b0;
      idle(1);
      check("flush_out_valid", obs_ov, 1'b0);
      bus.out_ready = 1'b1;
      set_in(1, 32'h50C, 5'd3, 1, 5'd9, 1, 5'd12, 1);
      cycle();
      check("flush_busy_clear", obs_rdy, 1'b1);
      idle(2);

      // Randomised traffic over a small register window
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 3) != 0, $urandom(),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         set_wb($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom());
         bus.out_ready = $urandom_range(0, 3) != 0;
         flush = $urandom_range(0, 40) == 0;
         cycle();
      end
      flush = 1'b0;
      bus.out_ready = 1'b1;
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
